// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control path:
// opcodes, state encodings, ALU/mux select codes and the control word.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  // Opcodes decoded by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // State encodings; the values are visible on the debug state port
  localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECUTE = 4'd6;
  localparam logic [STATE_W-1:0] S_ALUWB   = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH  = 4'd8;
  localparam logic [STATE_W-1:0] S_ADDIEX  = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIWB  = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP    = 4'd11;

  // aluop codes consumed by the downstream ALU function decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One cycle's worth of control outputs
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // True for the six opcodes the core implements
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The master is the controller, the slave
// is the datapath/memory side that supplies op and mem_ready.
//
// Handshake: mem_req is held high for as long as the controller is in a
// memory state (FETCH, MEMRD, MEMWR). The access completes on the rising
// edge where mem_req and mem_ready are both high; there is no separate
// acknowledge, and mem_ready is ignored whenever mem_req is low.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic               mem_ready;
  logic               mem_req;
  logic               memwrite;
  logic               irwrite;
  logic               pcwrite;
  logic               branch;
  logic               iord;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         aluop;
  logic [1:0]         pcsrc;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               illegal_op;
  logic               instr_done;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, mem_ready,
    output mem_req, memwrite, irwrite, pcwrite, branch, iord, alusrca,
           alusrcb, aluop, pcsrc, regdst, memtoreg, regwrite,
           illegal_op, instr_done, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, memwrite, irwrite, pcwrite, branch, iord, alusrca,
           alusrcb, aluop, pcsrc, regdst, memtoreg, regwrite,
           illegal_op, instr_done, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS-subset core. One state register,
// a next-state decoder and a Moore-style output decoder; the only inputs
// that reach the outputs directly are mem_ready (FETCH, MEMWR) and op
// (illegal_op in DECODE).
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  bus
);
  import mips_ctrl_pkg::*;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              ctrl;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // op is held by the instruction register, so only lw/sw arrive here
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted so
  // no strobe can fire in the cycle an instruction is aborted
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_req = 1'b1;
          ctrl.iord    = 1'b0;
          ctrl.alusrca = 1'b0;
          ctrl.alusrcb = ALUSRCB_FOUR;
          ctrl.aluop   = ALUOP_ADD;
          ctrl.pcsrc   = PCSRC_ALU;
          ctrl.irwrite = bus.mem_ready;
          ctrl.pcwrite = bus.mem_ready;
        end
        S_DECODE: begin
          // Branch target is computed speculatively into ALUOut here
          ctrl.alusrca    = 1'b0;
          ctrl.alusrcb    = ALUSRCB_IMMSH;
          ctrl.aluop      = ALUOP_ADD;
          ctrl.illegal_op = !is_legal_op(bus.op);
        end
        S_MEMADR: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = ALUSRCB_IMM;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctrl.mem_req = 1'b1;
          ctrl.iord    = 1'b1;
        end
        S_MEMWB: begin
          ctrl.regdst     = 1'b0;
          ctrl.memtoreg   = 1'b1;
          ctrl.regwrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_req    = 1'b1;
          ctrl.iord       = 1'b1;
          ctrl.memwrite   = 1'b1;
          ctrl.instr_done = bus.mem_ready;
        end
        S_EXECUTE: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = ALUSRCB_REGB;
          ctrl.aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctrl.regdst     = 1'b1;
          ctrl.memtoreg   = 1'b0;
          ctrl.regwrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alusrca    = 1'b1;
          ctrl.alusrcb    = ALUSRCB_REGB;
          ctrl.aluop      = ALUOP_SUB;
          ctrl.pcsrc      = PCSRC_ALUOUT;
          ctrl.branch     = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_ADDIEX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = ALUSRCB_IMM;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_ADDIWB: begin
          ctrl.regdst     = 1'b0;
          ctrl.memtoreg   = 1'b0;
          ctrl.regwrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JUMP: begin
          ctrl.pcsrc      = PCSRC_JUMP;
          ctrl.pcwrite    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.branch     = ctrl.branch;
  assign bus.iord       = ctrl.iord;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.aluop      = ctrl.aluop;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.instr_done = ctrl.instr_done;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized bench for the multi-cycle controller. Each
// instruction is expanded into its sequence of spec states (with memory
// stalls inserted), the expected control word per cycle comes from the
// per-state output table, and per-instruction latency is checked against
// the latency table.
module tb_multicycle_controller;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;
    logic       instr_done;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4)) bus();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [$bits(obs_t)-1:0] exp_q[$];

  function automatic obs_t sample();
    obs_t s;
    s.state      = bus.state;
    s.mem_req    = bus.mem_req;
    s.memwrite   = bus.memwrite;
    s.irwrite    = bus.irwrite;
    s.pcwrite    = bus.pcwrite;
    s.branch     = bus.branch;
    s.iord       = bus.iord;
    s.alusrca    = bus.alusrca;
    s.alusrcb    = bus.alusrcb;
    s.aluop      = bus.aluop;
    s.pcsrc      = bus.pcsrc;
    s.regdst     = bus.regdst;
    s.memtoreg   = bus.memtoreg;
    s.regwrite   = bus.regwrite;
    s.illegal_op = bus.illegal_op;
    s.instr_done = bus.instr_done;
    return s;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [5:0] op);
    return op == LW || op == SW || op == RTY || op == BEQ || op == ADDI || op == JMP;
  endfunction

  // Cycles per instruction with memory always ready
  function automatic int latency(input logic [5:0] op);
    case (op)
      LW:                   return 5;
      SW, RTY, ADDI:        return 4;
      BEQ, JMP:             return 3;
      default:              return 0;
    endcase
  endfunction

  // Control word required in a given state
  function automatic obs_t ref_out(input int st, input logic rdy, input logic [5:0] op);
    obs_t e;
    e = '0;
    e.state = 4'(st);
    case (st)
      0:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
      1:  begin e.alusrcb = 2'b11; e.illegal_op = !legal(op); end
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  begin e.mem_req = 1; e.iord = 1; end
      4:  begin e.memtoreg = 1; e.regwrite = 1; e.instr_done = 1; end
      5:  begin e.mem_req = 1; e.iord = 1; e.memwrite = 1; e.instr_done = rdy; end
      6:  begin e.alusrca = 1; e.aluop = 2'b10; end
      7:  begin e.regdst = 1; e.regwrite = 1; e.instr_done = 1; end
      8:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1; e.instr_done = 1; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: begin e.regwrite = 1; e.instr_done = 1; end
      11: begin e.pcsrc = 2'b10; e.pcwrite = 1; e.instr_done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_obs(input string tag, input obs_t got);
    obs_t e;
    e = obs_t'(exp_q.pop_front());
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (state %0d vs %0d)", tag, got, e, got.state, e.state);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs 1 ns later
  task automatic cyc(input logic r, input logic [5:0] o, input logic rdy,
                     input obs_t e, input string tag, output obs_t got);
    @(negedge clk);
    rst = r;
    bus.op = o;
    bus.mem_ready = rdy;
    #1;
    exp_q.push_back(e);
    got = sample();
    check_obs(tag, got);
  endtask

  // Runs one instruction from FETCH with fst FETCH stalls and mst stalls in
  // MEMRD/MEMWR, then checks its latency and done-pulse count.
  task automatic run_instr(input logic [5:0] o, input int fst, input int mst, input string tag);
    int   path[$];
    int   n, first_done, dones, stalls, lat_exp, dones_exp;
    logic rdy;
    obs_t g;
    path = '{0, 1};
    case (o)
      LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
      SW:   begin path.push_back(2); path.push_back(5); end
      RTY:  begin path.push_back(6); path.push_back(7); end
      BEQ:  path.push_back(8);
      ADDI: begin path.push_back(9); path.push_back(10); end
      JMP:  path.push_back(11);
      default: ;
    endcase
    n = 0; first_done = 0; dones = 0;
    foreach (path[k]) begin
      stalls = (path[k] == 0) ? fst : ((path[k] == 3 || path[k] == 5) ? mst : 0);
      for (int s = 0; s <= stalls; s++) begin
        if (path[k] == 0 || path[k] == 3 || path[k] == 5) rdy = (s == stalls);
        else rdy = 1'($urandom_range(0, 1));
        cyc(1'b0, o, rdy, ref_out(path[k], rdy, o), tag, g);
        n++;
        if (g.instr_done === 1'b1) begin
          dones++;
          if (first_done == 0) first_done = n;
        end
      end
    end
    lat_exp   = legal(o) ? latency(o) + fst + ((o == LW || o == SW) ? mst : 0) : 0;
    dones_exp = legal(o) ? 1 : 0;
    checks++;
    assert (first_done === lat_exp && dones === dones_exp) else begin
      errors++;
      $error("FAIL %s_latency observed=%0d/%0d expected=%0d/%0d (cycles/dones)",
             tag, first_done, dones, lat_exp, dones_exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obs_t z, g;
    logic [5:0] rop;
    rst = 1'b1;
    bus.op = 6'd0;
    bus.mem_ready = 1'b0;

    // Reset held for two cycles: FETCH with every output forced low
    z = '0;
    cyc(1'b1, LW, 1'b0, z, "reset0", g);
    cyc(1'b1, LW, 1'b1, z, "reset1", g);

    // Directed instructions
    run_instr(LW,   0, 0, "lw");
    run_instr(SW,   0, 3, "sw_stall3");
    run_instr(RTY,  0, 0, "rtype");
    run_instr(BEQ,  0, 0, "beq");
    run_instr(JMP,  0, 0, "j");
    run_instr(ADDI, 5, 0, "addi_fetch_stall5");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(LW,   1, 2, "lw_stalls");

    // Reset asserted in MEMWB: no regwrite, FETCH next cycle
    cyc(1'b0, LW, 1'b1, ref_out(0, 1'b1, LW), "rst_mid_fetch", g);
    cyc(1'b0, LW, 1'b0, ref_out(1, 1'b0, LW), "rst_mid_decode", g);
    cyc(1'b0, LW, 1'b0, ref_out(2, 1'b0, LW), "rst_mid_memadr", g);
    cyc(1'b0, LW, 1'b1, ref_out(3, 1'b1, LW), "rst_mid_memrd", g);
    z = '0;
    z.state = 4'd4;
    cyc(1'b1, LW, 1'b1, z, "rst_in_memwb", g);
    cyc(1'b0, JMP, 1'b1, ref_out(0, 1'b1, JMP), "after_rst_fetch", g);
    cyc(1'b0, JMP, 1'b0, ref_out(1, 1'b0, JMP), "after_rst_decode", g);
    cyc(1'b0, JMP, 1'b0, ref_out(11, 1'b0, JMP), "after_rst_jump", g);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: rop = LW;
        1: rop = SW;
        2: rop = RTY;
        3: rop = BEQ;
        4: rop = ADDI;
        5: rop = JMP;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
